lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_ctrl_if.sv | 35 +++
 rtl/lcd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style LCD write controller:
//   - controller state encoding
//   - bit positions inside the core's 32-bit LCD register
//   - default bus timing (in clock cycles)
//   - helper functions used to size and time the transaction counter
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } lcd_state_e;

    // Bit positions inside the core's LCD register.
    localparam int LCD_ON_BIT    = 31;
    localparam int LCD_START_BIT = 10;
    localparam int LCD_RS_BIT    = 9;
    localparam int LCD_DATA_MSB  = 7;
    localparam int LCD_DATA_LSB  = 0;

    // Default timing, in clock cycles.
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_EN    = 12;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_T_EXEC  = 2000;
    localparam int DEF_T_CLR   = 82000;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_if
// Bundles the core-side LCD register and the panel-side bus/status signals.
//   master : the CPU core side (drives lcd_reg, observes status and bus)
//   slave  : the controller side (consumes lcd_reg, drives status and bus)
// Signals:
//   lcd_reg  [31:0] core LCD register ([31] ON, [10] START, [9] RS, [7:0] DATA)
//   lcd_busy        transaction in progress
//   lcd_ovf         sticky: a START was dropped while busy
//   lcd_on          panel power/backlight
//   lcd_en          enable strobe
//   lcd_rs          register select (0 = command, 1 = data)
//   lcd_rw          read/write (always write)
//   lcd_data [7:0]  LCD data bus
// ---------------------------------------------------------------------------
interface lcd_ctrl_if;
    logic [31:0] lcd_reg;
    logic        lcd_busy;
    logic        lcd_ovf;
    logic        lcd_on;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    modport master (
        output lcd_reg,
        input  lcd_busy, lcd_ovf, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  lcd_reg,
        output lcd_busy, lcd_ovf, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
// Write-only HD44780 bus sequencer. A rising edge on START (register bit 10)
// latches RS/DATA onto the bus and runs SETUP -> PULSE (EN high) -> HOLD ->
// EXEC (settle), then returns to IDLE. A START edge seen while a transaction
// is running is dropped and recorded in the sticky overflow flag.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_lcd_reg   core LCD register ([31] ON, [10] START, [9] RS, [7:0] DATA)
//   o_lcd_busy  transaction in progress
//   o_lcd_ovf   sticky dropped-START flag, cleared only by reset
//   o_lcd_on    panel power, i_lcd_reg[31] delayed one cycle
//   o_lcd_en    enable strobe
//   o_lcd_rs    register select
//   o_lcd_rw    read/write, always 0
//   o_lcd_data  data bus
// ---------------------------------------------------------------------------
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_EN    = DEF_T_EN,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_EXEC  = DEF_T_EXEC,
    parameter int T_CLR   = DEF_T_CLR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_busy,
    output logic        o_lcd_ovf,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    // One counter serves every state, so it is sized for the longest phase.
    localparam int T_MAX = max_int(max_int(T_CLR, T_EXEC),
                                   max_int(T_EN, max_int(T_SETUP, T_HOLD)));
    localparam int CNT_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             on_q;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic             rw_q;
    logic [7:0]       data_q, data_d;

    logic             launch;
    logic             last;
    logic             accept;

    // Register bits that carry no meaning for this block.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

    assign launch = i_lcd_reg[LCD_START_BIT] & ~start_q;
    assign last   = (cnt_q == CNT_ZERO);
    // A launch is taken in IDLE, or on the very edge EXEC finishes so that
    // back-to-back writes need no idle cycle in between.
    assign accept = launch & ((state_q == ST_IDLE) | ((state_q == ST_EXEC) & last));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ovf_d   = ovf_q | (launch & ~accept);

        // Phase countdown; it only moves while non-zero, so it never wraps.
        if ((state_q != ST_IDLE) && !last) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
            end
            ST_SETUP: begin
                if (last) begin
                    state_d = ST_PULSE;
                    en_d    = 1'b1;
                    cnt_d   = LD_EN;
                end
            end
            ST_PULSE: begin
                if (last) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (last) begin
                    state_d = ST_EXEC;
                    cnt_d   = is_slow_cmd(rs_q, data_q) ? LD_CLR : LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Launch overrides the idle/return path above.
        if (accept) begin
            state_d = ST_SETUP;
            cnt_d   = LD_SETUP;
            busy_d  = 1'b1;
            en_d    = 1'b0;
            rs_d    = i_lcd_reg[LCD_RS_BIT];
            data_d  = i_lcd_reg[LCD_DATA_MSB:LCD_DATA_LSB];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            on_q    <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= i_lcd_reg[LCD_START_BIT];
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            on_q    <= i_lcd_reg[LCD_ON_BIT];
            en_q    <= en_d;
            rs_q    <= rs_d;
            rw_q    <= 1'b0;
            data_q  <= data_d;
        end
    end

    assign o_lcd_busy = busy_q;
    assign o_lcd_ovf  = ovf_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = rw_q;
    assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl
// Directed scenarios (data write, clear, dropped start, back-to-back launch,
// reset mid-pulse, ON pass-through) followed by randomized register traffic.
// A transaction-level model predicts busy/en/rs/data/ovf/on every cycle.
// Execution times are shortened so a clear fits in the run.
// ---------------------------------------------------------------------------
module tb_lcd_ctrl;

    localparam int TS = 2;
    localparam int TE = 12;
    localparam int TH = 2;
    localparam int TX = 40;
    localparam int TC = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_ctrl_if lif();

    lcd_ctrl #(
        .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_CLR(TC)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lcd_reg  (lif.lcd_reg),
        .o_lcd_busy (lif.lcd_busy),
        .o_lcd_ovf  (lif.lcd_ovf),
        .o_lcd_on   (lif.lcd_on),
        .o_lcd_en   (lif.lcd_en),
        .o_lcd_rs   (lif.lcd_rs),
        .o_lcd_rw   (lif.lcd_rw),
        .o_lcd_data (lif.lcd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_left  : busy cycles still to come (including the current one)
    // m_age   : cycles since the last accepted launch edge
    int         m_left  = 0;
    int         m_age   = 1000;
    int         m_txn   = 0;
    logic       m_prev  = 1'b0;
    logic       m_rs    = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_on    = 1'b0;
    logic       m_start;
    int         m_total;

    assign m_start = lif.lcd_reg[10] & ~m_prev;
    assign m_total = TS + TE + TH +
                     ((!lif.lcd_reg[9] && lif.lcd_reg[7:0] >= 8'd1 && lif.lcd_reg[7:0] <= 8'd3) ? TC : TX);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_age  <= 1000;
            m_prev <= 1'b0;
            m_rs   <= 1'b0;
            m_data <= 8'h00;
            m_ovf  <= 1'b0;
            m_on   <= 1'b0;
        end else begin
            if (m_start && m_left <= 1) begin
                m_left <= m_total;
                m_age  <= 0;
                m_rs   <= lif.lcd_reg[9];
                m_data <= lif.lcd_reg[7:0];
                m_txn  <= m_txn + 1;
                $display("txn %0d: rs=%0d data=%02h busy_cycles=%0d", m_txn, lif.lcd_reg[9],
                         lif.lcd_reg[7:0], m_total);
            end else begin
                if (m_start) m_ovf <= 1'b1;
                if (m_left > 0) m_left <= m_left - 1;
                if (m_age < 1000) m_age <= m_age + 1;
            end
            m_prev <= lif.lcd_reg[10];
            m_on   <= lif.lcd_reg[31];
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cyc_busy", lif.lcd_busy, (m_left > 0));
            check("cyc_en",   lif.lcd_en,   (m_left > 0) && (m_age >= TS) && (m_age < TS + TE));
            check("cyc_rs",   lif.lcd_rs,   m_rs);
            check("cyc_data", lif.lcd_data, m_data);
            check("cyc_ovf",  lif.lcd_ovf,  m_ovf);
            check("cyc_on",   lif.lcd_on,   m_on);
            check("cyc_rw",   lif.lcd_rw,   1'b0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic go_idle(input int n);
        @(negedge clk);
        lif.lcd_reg = 32'h0;
        repeat (n) @(posedge clk);
    endtask

    // Drive a START edge and check the bus right after the launch edge.
    task automatic launch(input logic [31:0] v, input string tag, input logic exp_rs,
                          input logic [7:0] exp_data);
        @(negedge clk);
        lif.lcd_reg = v;
        @(posedge clk);
        #1;
        check({tag, "_busy0"}, lif.lcd_busy, 1'b1);
        check({tag, "_rs"},    lif.lcd_rs,   exp_rs);
        check({tag, "_data"},  lif.lcd_data, exp_data);
    endtask

    // Count from the current sample (launch edge = sample 0) until busy drops.
    task automatic measure(input string tag, output int en_first, output int en_cnt,
                           output int busy_cnt);
        int k;
        k = 0;
        en_first = -1;
        en_cnt = 0;
        busy_cnt = 0;
        while (lif.lcd_busy === 1'b1 && k < 1000) begin
            if (lif.lcd_en === 1'b1) begin
                if (en_first < 0) en_first = k;
                en_cnt++;
            end
            busy_cnt++;
            k++;
            @(posedge clk);
            #1;
        end
        check({tag, "_ends_idle"}, lif.lcd_busy, 1'b0);
        $display("%s: en_first=%0d en_cycles=%0d busy_cycles=%0d", tag, en_first, en_cnt, busy_cnt);
    endtask

    int ef, ec, bc;

    initial begin
        lif.lcd_reg = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", lif.lcd_busy, 1'b0);
        check("rst_en",   lif.lcd_en,   1'b0);
        check("rst_ovf",  lif.lcd_ovf,  1'b0);
        check("rst_data", lif.lcd_data, 8'h00);
        rst_n = 1'b1;
        go_idle(2);

        // Data write.
        launch(32'h0000_0641, "wr", 1'b1, 8'h41);
        measure("wr", ef, ec, bc);
        check("wr_en_first", ef, 2);
        check("wr_en_cycles", ec, 12);
        check("wr_busy_cycles", bc, 56);

        // Clear command takes the long settle time.
        go_idle(2);
        launch(32'h0000_0401, "clr", 1'b0, 8'h01);
        measure("clr", ef, ec, bc);
        check("clr_en_cycles", ec, 12);
        check("clr_busy_cycles", bc, 316);

        // Dropped start during EXEC.
        go_idle(2);
        launch(32'h0000_0641, "drop", 1'b1, 8'h41);
        fork
            measure("drop", ef, ec, bc);
            begin
                repeat (20) @(negedge clk);
                lif.lcd_reg[10] = 1'b0;
                @(negedge clk);
                lif.lcd_reg[10] = 1'b1;
            end
        join
        check("drop_ovf", lif.lcd_ovf, 1'b1);
        check("drop_en_cycles", ec, 12);
        check("drop_busy_cycles", bc, 56);
        repeat (10) @(posedge clk);
        #1;
        check("drop_no_relaunch", lif.lcd_busy, 1'b0);
        check("drop_ovf_sticky", lif.lcd_ovf, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("drop_ovf_cleared", lif.lcd_ovf, 1'b0);
        @(negedge clk);
        lif.lcd_reg = 32'h0;
        rst_n = 1'b1;
        go_idle(2);

        // Back-to-back: new START edge lands on the busy-falling edge.
        launch(32'h0000_0641, "b2b", 1'b1, 8'h41);
        for (int k = 0; k < 56; k++) begin
            if (k == 54) begin
                @(negedge clk);
                lif.lcd_reg = 32'h0000_0241;
            end else if (k == 55) begin
                @(negedge clk);
                lif.lcd_reg = 32'h0000_0642;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_busy_held", lif.lcd_busy, 1'b1);
        check("b2b_data", lif.lcd_data, 8'h42);
        check("b2b_no_ovf", lif.lcd_ovf, 1'b0);
        measure("b2b2", ef, ec, bc);
        check("b2b_en_first", ef, 2);
        check("b2b_busy_cycles", bc, 56);

        // Reset in the middle of the EN pulse, START held high across it.
        go_idle(2);
        launch(32'h0000_0641, "rstp", 1'b1, 8'h41);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("rstp_en_before", lif.lcd_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstp_en", lif.lcd_en, 1'b0);
        check("rstp_busy", lif.lcd_busy, 1'b0);
        check("rstp_rs", lif.lcd_rs, 1'b0);
        check("rstp_data", lif.lcd_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstp_relaunch", lif.lcd_busy, 1'b1);
        check("rstp_re_data", lif.lcd_data, 8'h41);
        measure("rstp2", ef, ec, bc);
        check("rstp_busy_cycles", bc, 56);

        // ON pass-through, idle and busy.
        go_idle(2);
        @(negedge clk);
        lif.lcd_reg = 32'h8000_0000;
        @(posedge clk);
        #1;
        check("on_idle_1", lif.lcd_on, 1'b1);
        @(negedge clk);
        lif.lcd_reg = 32'h0;
        @(posedge clk);
        #1;
        check("on_idle_0", lif.lcd_on, 1'b0);
        launch(32'h0000_0641, "on", 1'b1, 8'h41);
        fork
            measure("on", ef, ec, bc);
            begin
                repeat (5) @(negedge clk);
                lif.lcd_reg[31] = 1'b1;
                @(posedge clk);
                #1;
                check("on_busy_1", lif.lcd_on, 1'b1);
                @(negedge clk);
                lif.lcd_reg[31] = 1'b0;
                @(posedge clk);
                #1;
                check("on_busy_0", lif.lcd_on, 1'b0);
            end
        join
        check("on_en_cycles", ec, 12);
        check("on_busy_cycles", bc, 56);

        // Randomized register traffic against the model.
        for (int s = 0; s < 300; s++) begin
            logic [31:0] v;
            int hold;
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v[7:0] = 8'($urandom_range(0, 3));
            hold = $urandom_range(1, 25);
            @(negedge clk);
            lif.lcd_reg = v;
            repeat (hold) @(posedge clk);
            if ($urandom_range(0, 79) == 0) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        go_idle(1);
        measure("tail", ef, ec, bc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
